// File: rtl/key_switch_input_pkg.sv
// Register map shared by the key/switch input peripheral, the bridge decoder
// and the software headers.
package key_switch_input_pkg;

  localparam logic [1:0] SW_LO = 2'd0;
  localparam logic [1:0] SW_HI = 2'd1;
  localparam logic [1:0] KEY   = 2'd2;
  localparam logic [1:0] CTRL  = 2'd3;

  localparam int PEND_LSB = 0;
  localparam int MASK_LSB = 8;

endpackage

// File: rtl/key_switch_input_key_debouncer.sv
// One push-button: 2-flop synchroniser, inversion to pressed-high, and a
// hold counter that accepts a new level after DEBOUNCE_CYCLES cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic Clk,
  input  logic Reset,
  input  logic keyN_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             level;
  logic             accept;

  assign level    = ~sync_q[1];
  assign accept   = (level != stable_q) && (cnt_q == CNT_LAST);
  assign press_o  = accept && level;
  assign stable_o = stable_q;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (level == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = level;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sync flops reset to the released level so a held key re-debounces cleanly.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], keyN_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/key_switch_input.sv
// Bus-slave input peripheral: debounced DIP switches and push-buttons, sticky
// key-press pending bits and a maskable level interrupt.
module key_switch_input
  import key_switch_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ,
  input  logic [63:0] dip_sw,
  input  logic [7:0]  key_n
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [63:0]      swSync1_q, swSync2_q, swSample_q, swStable_q;
  logic [CNT_W-1:0] tickCnt_q;
  logic             tick;
  logic [7:0]       keyStable, keyPress;
  logic [7:0]       pending_q, pending_d;
  logic [7:0]       mask_q, mask_d;
  logic             irq_q;
  logic             ctrlWrite;
  logic             unusedBits;

  assign unusedBits = ^{BE[3:2], DIn[31:16]};

  for (genvar i = 0; i < 8; i++) begin : gKey
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) uDebouncer (
      .Clk     (Clk),
      .Reset   (Reset),
      .keyN_i  (key_n[i]),
      .stable_o(keyStable[i]),
      .press_o (keyPress[i])
    );
  end

  assign tick      = (tickCnt_q == TICK_LAST);
  assign ctrlWrite = WE && (Addr == CTRL);

  // A press landing together with a W1C of the same bit keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    if (ctrlWrite && BE[0]) begin
      pending_d = pending_q & ~DIn[PEND_LSB +: 8];
    end
    pending_d = pending_d | keyPress;
    if (ctrlWrite && BE[1]) begin
      mask_d = DIn[MASK_LSB +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      swSync1_q  <= '0;
      swSync2_q  <= '0;
      swSample_q <= '0;
      swStable_q <= '0;
      tickCnt_q  <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      swSync1_q <= dip_sw;
      swSync2_q <= swSync1_q;
      tickCnt_q <= tick ? '0 : tickCnt_q + CNT_W'(1);
      // Switches are accepted only when two successive tick samples agree.
      if (tick) begin
        swSample_q <= swSync2_q;
        if (swSync2_q == swSample_q) begin
          swStable_q <= swSync2_q;
        end
      end
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= |(pending_q & mask_q);
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    DOut = '0;
    case (Addr)
      SW_LO:   DOut = swStable_q[31:0];
      SW_HI:   DOut = swStable_q[63:32];
      KEY:     DOut = {24'b0, keyStable};
      default: DOut = {16'b0, mask_q, pending_q};
    endcase
  end

endmodule
